// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter with valid/ready word load and bit-rate enable.
// Optional even-parity trailer bit is built in when PISO_TX_PARITY_EN is defined.
module piso_tx #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             bit_en,
    output logic             d,
    output logic             v,
    output logic             sof,
    output logic             eof,
    output logic             busy
);
    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PISO_TX_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             d_n, v_n, sof_n, eof_n, busy_n;
    logic             accept;
    logic             cur_bit;
    logic [WIDTH-1:0] shifted;
`ifdef PISO_TX_PARITY_EN
    logic             par, par_n;
`endif

    always_comb begin
        if (MSB_FIRST != 0) begin
            cur_bit = shreg[WIDTH-1];
            shifted = {shreg[WIDTH-2:0], 1'b0};
        end else begin
            cur_bit = shreg[0];
            shifted = {1'b0, shreg[WIDTH-1:1]};
        end
    end

    // din_ready opens in IDLE and in the final enabled bit cycle so frames can stream back-to-back
    always_comb begin
        din_ready = 1'b0;
        case (state)
            IDLE:  din_ready = 1'b1;
`ifdef PISO_TX_PARITY_EN
            PAR:   din_ready = bit_en;
`else
            SHIFT: din_ready = bit_en && (cnt == LAST);
`endif
            default: din_ready = 1'b0;
        endcase
        if (reset) begin
            din_ready = 1'b0;
        end
    end

    assign accept = din_valid && din_ready;

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        cnt_n   = cnt;
        d_n     = d;
        v_n     = 1'b0;
        sof_n   = 1'b0;
        eof_n   = 1'b0;
`ifdef PISO_TX_PARITY_EN
        par_n   = par;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    shreg_n = din;
                    cnt_n   = '0;
                    state_n = SHIFT;
`ifdef PISO_TX_PARITY_EN
                    par_n   = ^din;
`endif
                end
            end
            SHIFT: begin
                if (bit_en) begin
                    d_n     = cur_bit;
                    v_n     = 1'b1;
                    sof_n   = (cnt == '0);
                    shreg_n = shifted;
                    cnt_n   = cnt + CW'(1);
                    if (cnt == LAST) begin
                        cnt_n = '0;
`ifdef PISO_TX_PARITY_EN
                        state_n = PAR;
`else
                        eof_n = 1'b1;
                        if (accept) begin
                            shreg_n = din;
                        end else begin
                            state_n = IDLE;
                        end
`endif
                    end
                end
            end
`ifdef PISO_TX_PARITY_EN
            PAR: begin
                if (bit_en) begin
                    d_n   = par;
                    v_n   = 1'b1;
                    eof_n = 1'b1;
                    if (accept) begin
                        shreg_n = din;
                        cnt_n   = '0;
                        par_n   = ^din;
                        state_n = SHIFT;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
`endif
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
            d     <= 1'b0;
            v     <= 1'b0;
            sof   <= 1'b0;
            eof   <= 1'b0;
            busy  <= 1'b0;
`ifdef PISO_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_n;
            shreg <= shreg_n;
            cnt   <= cnt_n;
            d     <= d_n;
            v     <= v_n;
            sof   <= sof_n;
            eof   <= eof_n;
            busy  <= busy_n;
`ifdef PISO_TX_PARITY_EN
            par   <= par_n;
`endif
        end
    end

endmodule
